// File: rtl/sdram_slot_arbiter.sv
// Slot arbiter for the shared 8-clock SDRAM port: generates slot phase/sync, holds off grants
// during SDRAM init and picks video, CPU or aux per slot, leaving idle slots for auto-refresh.
module sdram_slot_arbiter #(
    parameter int INIT_SLOTS  = 40,
    parameter int REFRESH_MAX = 8,
    parameter int AUX_MAX     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_init,
    output logic        mem_sync,
    output logic [23:0] mem_addr,
    output logic [1:0]  mem_ds,
    output logic [15:0] mem_din,
    output logic        mem_oe,
    output logic        mem_we,
    input  logic [15:0] mem_dout,
    input  logic        vid_req,
    input  logic [23:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_ds,
    input  logic [23:0] cpu_addr,
    input  logic [15:0] cpu_din,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [1:0]  aux_ds,
    input  logic [23:0] aux_addr,
    input  logic [15:0] aux_din,
    output logic        aux_ack,
    output logic [15:0] aux_rdata
);
    localparam int IW = $clog2(INIT_SLOTS + 1);
    localparam int BW = $clog2(REFRESH_MAX + 1);
    localparam int AW = $clog2(AUX_MAX + 1);

    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU, OWN_AUX} owner_t;

    logic [2:0]    ph;
    logic [IW-1:0] init_cnt;
    logic [BW-1:0] busy_cnt, busy_nxt;
    logic [AW-1:0] aux_skip, skip_nxt;
    owner_t        owner, owner_nxt;
    logic          slot_end, vid_ok, cpu_ok, aux_ok;

    // The owner of the slot now running still has its req high; it must not be re-granted.
    always_comb begin
        slot_end  = (ph == 3'd7);
        vid_ok    = vid_req && (owner != OWN_VID);
        cpu_ok    = cpu_req && (owner != OWN_CPU);
        aux_ok    = aux_req && (owner != OWN_AUX);
        owner_nxt = OWN_NONE;
        if (!mem_init && (busy_cnt < BW'(REFRESH_MAX))) begin
            if (vid_ok)
                owner_nxt = OWN_VID;
            else if (aux_ok && (aux_skip >= AW'(AUX_MAX)))
                owner_nxt = OWN_AUX;
            else if (cpu_ok)
                owner_nxt = OWN_CPU;
            else if (aux_ok)
                owner_nxt = OWN_AUX;
        end
        busy_nxt = (owner_nxt == OWN_NONE) ? '0 : busy_cnt + 1'b1;
        if (mem_init || !aux_ok || (owner_nxt == OWN_AUX))
            skip_nxt = '0;
        else if (aux_skip < AW'(AUX_MAX))
            skip_nxt = aux_skip + 1'b1;
        else
            skip_nxt = aux_skip;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph        <= '0;
            mem_sync  <= 1'b0;
            mem_init  <= 1'b1;
            init_cnt  <= '0;
            busy_cnt  <= '0;
            aux_skip  <= '0;
            owner     <= OWN_NONE;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_ds    <= '0;
            mem_din   <= '0;
            vid_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            aux_ack   <= 1'b0;
            vid_rdata <= '0;
            cpu_rdata <= '0;
            aux_rdata <= '0;
        end else begin
            ph       <= ph + 3'd1;
            mem_sync <= (ph == 3'd7) || (ph < 3'd3);
            vid_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            aux_ack  <= 1'b0;
            if (slot_end) begin
                if (mem_init) begin
                    if (init_cnt == IW'(INIT_SLOTS - 1))
                        mem_init <= 1'b0;
                    init_cnt <= init_cnt + 1'b1;
                end
                case (owner)
                    OWN_VID: begin
                        vid_ack   <= 1'b1;
                        vid_rdata <= mem_dout;
                    end
                    OWN_CPU: begin
                        cpu_ack <= 1'b1;
                        if (mem_oe) cpu_rdata <= mem_dout;
                    end
                    OWN_AUX: begin
                        aux_ack <= 1'b1;
                        if (mem_oe) aux_rdata <= mem_dout;
                    end
                    default: ;
                endcase
                owner    <= owner_nxt;
                busy_cnt <= busy_nxt;
                aux_skip <= skip_nxt;
                // Idle slots and read slots drive zero on the fields they do not use.
                mem_oe   <= 1'b0;
                mem_we   <= 1'b0;
                mem_addr <= '0;
                mem_ds   <= '0;
                mem_din  <= '0;
                case (owner_nxt)
                    OWN_VID: begin
                        mem_oe   <= 1'b1;
                        mem_addr <= vid_addr;
                        mem_ds   <= 2'b11;
                    end
                    OWN_CPU: begin
                        mem_oe   <= !cpu_we;
                        mem_we   <= cpu_we;
                        mem_addr <= cpu_addr;
                        mem_ds   <= cpu_ds;
                        if (cpu_we) mem_din <= cpu_din;
                    end
                    OWN_AUX: begin
                        mem_oe   <= !aux_we;
                        mem_we   <= aux_we;
                        mem_addr <= aux_addr;
                        mem_ds   <= aux_ds;
                        if (aux_we) mem_din <= aux_din;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Scoreboard bench for sdram_slot_arbiter: random requesters, slot-level reference model,
// and a monitor comparing every cycle of the SDRAM port and the acknowledge/read-data outputs.
module tb_sdram_slot_arbiter;
    localparam int INIT_SLOTS  = 40;
    localparam int REFRESH_MAX = 8;
    localparam int AUX_MAX     = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_init, mem_sync, mem_oe, mem_we;
    logic [23:0] mem_addr;
    logic [1:0]  mem_ds;
    logic [15:0] mem_din, mem_dout;
    logic        vid_req, vid_ack;
    logic [23:0] vid_addr;
    logic [15:0] vid_rdata;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [1:0]  cpu_ds;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_din, cpu_rdata;
    logic        aux_req, aux_we, aux_ack;
    logic [1:0]  aux_ds;
    logic [23:0] aux_addr;
    logic [15:0] aux_din, aux_rdata;

    sdram_slot_arbiter #(.INIT_SLOTS(INIT_SLOTS), .REFRESH_MAX(REFRESH_MAX), .AUX_MAX(AUX_MAX)) dut (
        .clk(clk), .reset_n(rst_n), .mem_init(mem_init), .mem_sync(mem_sync),
        .mem_addr(mem_addr), .mem_ds(mem_ds), .mem_din(mem_din), .mem_oe(mem_oe),
        .mem_we(mem_we), .mem_dout(mem_dout),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ds(cpu_ds), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_ds(aux_ds), .aux_addr(aux_addr),
        .aux_din(aux_din), .aux_ack(aux_ack), .aux_rdata(aux_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        oe;
        logic        we;
        logic [23:0] addr;
        logic [1:0]  ds;
        logic [15:0] din;
    } grant_t;

    typedef struct packed {
        logic [1:0]  owner;
        logic [15:0] rv;
        logic [15:0] rc;
        logic [15:0] ra;
    } ack_t;

    grant_t g_q[$];
    ack_t   a_q[$];
    int     n_chk = 0;
    int     n_fail = 0;
    int     edges;
    int     cur_ph;
    int     vid_mode, cpu_mode, aux_mode;
    logic   vid_wd, cpu_wd, aux_wd;
    int     n_cpu_ack = 0;
    int     cpu_ack_edge = 0;

    // reference model state: slot history instead of counters
    int          hist[$];
    bit          auxh[$];
    int          m_owner;
    logic        m_we;
    logic [15:0] dout_cur, e_rv, e_rc, e_ra;
    logic [15:0] mem_m [logic [23:0]];

    always @(posedge clk or negedge rst_n)
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        auxh.delete();
        g_q.delete();
        a_q.delete();
        m_owner  = 0;
        m_we     = 1'b0;
        e_rv     = '0;
        e_rc     = '0;
        e_ra     = '0;
        dout_cur = 16'($urandom);
    endtask

    // Slot-boundary reference: ends the running slot and picks the next owner.
    task automatic decide();
        int     k, run, skip, nxt;
        bit     ael;
        grant_t g;
        k = (edges + 1) / 8;
        mem_dout = dout_cur;
        if (m_owner != 0 && !m_we) begin
            if (m_owner == 1)      e_rv = dout_cur;
            else if (m_owner == 2) e_rc = dout_cur;
            else                   e_ra = dout_cur;
        end
        a_q.push_back('{owner: 2'(m_owner), rv: e_rv, rc: e_rc, ra: e_ra});
        nxt = 0;
        ael = aux_req && (m_owner != 3);
        if (k > INIT_SLOTS) begin
            run = 0;
            for (int i = hist.size() - 1; i >= 0 && hist[i] != 0; i--) run++;
            skip = 0;
            for (int i = auxh.size() - 1; i >= 0 && auxh[i]; i--) skip++;
            if (run < REFRESH_MAX) begin
                if (vid_req && m_owner != 1)          nxt = 1;
                else if (ael && skip >= AUX_MAX)      nxt = 3;
                else if (cpu_req && m_owner != 2)     nxt = 2;
                else if (ael)                         nxt = 3;
            end
            hist.push_back(nxt);
            auxh.push_back(ael && nxt != 3);
        end else begin
            hist.push_back(0);
            auxh.push_back(1'b0);
        end
        g = '0;
        if (nxt == 1) begin
            g.oe = 1'b1; g.addr = vid_addr; g.ds = 2'b11;
        end else if (nxt == 2) begin
            g.we = cpu_we; g.oe = !cpu_we; g.addr = cpu_addr; g.ds = cpu_ds;
            g.din = cpu_we ? cpu_din : 16'h0;
        end else if (nxt == 3) begin
            g.we = aux_we; g.oe = !aux_we; g.addr = aux_addr; g.ds = aux_ds;
            g.din = aux_we ? aux_din : 16'h0;
        end
        g_q.push_back(g);
        if (g.we) begin
            mem_m[g.addr] = g.din;
            dout_cur = 16'($urandom);
        end else if (g.oe && mem_m.exists(g.addr)) dout_cur = mem_m[g.addr];
        else dout_cur = 16'($urandom);
        m_owner = nxt;
        m_we    = g.we;
    endtask

    // mode 0: finish current request then stay idle; 1: random with withdrawals; 2: always requesting
    task automatic agent(input int mode, input int ph, input logic ack,
                         inout logic req, inout logic wd, output logic fresh);
        fresh = 1'b0;
        if (req && ack) begin
            wd = 1'b0;
            if (mode == 2 || (mode == 1 && $urandom_range(1, 0) == 1)) fresh = 1'b1;
            else req = 1'b0;
        end else if (!req && mode != 0) begin
            if (mode == 2 || $urandom_range(3, 0) == 0) begin
                fresh = 1'b1;
                req   = 1'b1;
                wd    = (mode == 1 && ph == 1 && $urandom_range(2, 0) == 0);
            end
        end else if (req && wd && ph == 5) begin
            req = 1'b0;
            wd  = 1'b0;
        end
    endtask

    task automatic step();
        logic f;
        @(negedge clk);
        cur_ph = edges % 8;
        if (cur_ph != 7) mem_dout = 16'($urandom);
        if (cpu_req && cpu_ack) begin
            n_cpu_ack++;
            cpu_ack_edge = edges;
        end
        agent(vid_mode, cur_ph, vid_ack, vid_req, vid_wd, f);
        if (f) vid_addr = 24'($urandom_range(15, 0));
        agent(cpu_mode, cur_ph, cpu_ack, cpu_req, cpu_wd, f);
        if (f) begin
            cpu_we = 1'($urandom); cpu_ds = 2'($urandom_range(3, 1));
            cpu_addr = 24'($urandom_range(15, 0)); cpu_din = 16'($urandom);
        end
        agent(aux_mode, cur_ph, aux_ack, aux_req, aux_wd, f);
        if (f) begin
            aux_we = 1'($urandom); aux_ds = 2'($urandom_range(3, 1));
            aux_addr = 24'($urandom_range(15, 0)); aux_din = 16'($urandom);
        end
        if (rst_n && cur_ph == 7) decide();
    endtask

    task automatic wait_cpu_ack(input int bound, input string nm);
        int start;
        start = n_cpu_ack;
        for (int i = 0; i < bound && n_cpu_ack == start; i++) step();
        if (n_cpu_ack == start) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no cpu_ack within %0d cycles", nm, bound);
        end
    endtask

    // monitor: compares every cycle against the model's queued slot expectations
    initial begin
        grant_t cur_g;
        ack_t   ae;
        int     mph;
        cur_g = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                cur_g = '0;
                chk("rst_init", mem_init, 1);
                chk("rst_sync", mem_sync, 0);
                chk("rst_oe_we", {mem_oe, mem_we}, 0);
                chk("rst_addr_ds_din", {mem_addr, mem_ds, mem_din}, 0);
                chk("rst_acks", {vid_ack, cpu_ack, aux_ack}, 0);
                chk("rst_rdata", {vid_rdata, cpu_rdata}, 0);
                chk("rst_aux_rdata", aux_rdata, 0);
            end else if (edges >= 1) begin
                mph = edges % 8;
                if (mph == 0) begin
                    if (g_q.size() == 0 || a_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL scoreboard_empty: no expected slot at edge %0d", edges);
                    end else begin
                        cur_g = g_q.pop_front();
                        ae    = a_q.pop_front();
                        chk("vid_ack", vid_ack, ae.owner == 2'd1);
                        chk("cpu_ack", cpu_ack, ae.owner == 2'd2);
                        chk("aux_ack", aux_ack, ae.owner == 2'd3);
                        chk("vid_rdata", vid_rdata, ae.rv);
                        chk("cpu_rdata", cpu_rdata, ae.rc);
                        chk("aux_rdata", aux_rdata, ae.ra);
                    end
                end else begin
                    chk("ack_single_pulse", {vid_ack, cpu_ack, aux_ack}, 0);
                end
                chk("mem_init", mem_init, edges < 8 * INIT_SLOTS);
                chk("mem_sync", mem_sync, mph < 4);
                chk("mem_oe", mem_oe, cur_g.oe);
                chk("mem_we", mem_we, cur_g.we);
                chk("mem_addr", mem_addr, cur_g.addr);
                chk("mem_ds", mem_ds, cur_g.ds);
                chk("mem_din", mem_din, cur_g.din);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        {vid_req, cpu_req, aux_req, cpu_we, aux_we} = '0;
        {vid_wd, cpu_wd, aux_wd} = '0;
        vid_addr = '0; cpu_addr = '0; aux_addr = '0;
        cpu_ds = '0; aux_ds = '0; cpu_din = '0; aux_din = '0;
        mem_dout = '0;
        vid_mode = 0; cpu_mode = 0; aux_mode = 0;
        cur_ph = 0;
        repeat (3) @(negedge clk);
        model_reset();
        // CPU write held through init, then read-back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h012345; cpu_din = 16'hBEEF; cpu_ds = 2'b01;
        rst_n = 1'b1;
        wait_cpu_ack(8 * INIT_SLOTS + 40, "first_write");
        chk("first_ack_edge", cpu_ack_edge, 8 * (INIT_SLOTS + 2));
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_ds = 2'b11; cpu_din = '0;
        wait_cpu_ack(64, "read_back");
        chk("read_back_beef", cpu_rdata, 16'hBEEF);
        // random traffic from all three requesters
        vid_mode = 1; cpu_mode = 1; aux_mode = 1;
        repeat (8 * 150) step();
        // continuous requests, then video retires
        vid_mode = 2; cpu_mode = 2; aux_mode = 2;
        repeat (8 * 40) step();
        vid_mode = 0;
        repeat (8 * 100) step();
        cpu_mode = 0; aux_mode = 0;
        for (int i = 0; i < 400 && (vid_req || cpu_req || aux_req); i++) step();
        chk("drain_reqs", {vid_req, cpu_req, aux_req}, 0);
        // withdrawn request: raised at ph1, dropped at ph5
        for (int i = 0; i < 16 && cur_ph != 1; i++) step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h000007; cpu_din = 16'h1234; cpu_ds = 2'b11;
        for (int i = 0; i < 16 && cur_ph != 5; i++) step();
        cpu_req = 1'b0;
        repeat (8 * 3) step();
        // reset in the middle of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000003; cpu_ds = 2'b10;
        for (int i = 0; i < 64 && !(m_owner == 2 && !m_we); i++) step();
        for (int i = 0; i < 16 && cur_ph != 3; i++) step();
        chk("reset_point_owner", m_owner, 2);
        rst_n = 1'b0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        wait_cpu_ack(8 * INIT_SLOTS + 40, "after_reset");
        chk("restart_ack_edge", cpu_ack_edge, 8 * (INIT_SLOTS + 2));
        repeat (8 * 4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
